// File: rtl/link_tx_framer.sv
// link_tx_framer: 20-bit link framer; buffers 18-bit payload in a FIFO and inserts 20'hFFFFF every FRAME_LEN words.
// Optional marker corruption for receiver testing is built when LINK_TX_ERRINJ_EN is defined.
module link_tx_framer #(
  parameter int FRAME_LEN = 3900,
  parameter int DEPTH     = 16
) (
  input  logic                     iSclk,
  input  logic                     iRstN,
  input  logic                     iEn,
  input  logic [17:0]              iData,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic                     iErrInj,
  output logic [19:0]              oD_Link,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic [15:0]              oFrameCnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(FRAME_LEN);
  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_MARK = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [19:0]   link_q, link_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [AW:0]   level_q, level_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [17:0]   mem_q [DEPTH];
  logic [19:0]   marker;
  logic          push, pop, last;
`ifdef LINK_TX_ERRINJ_EN
  logic err_req_q, err_req_d;
  // A pulse arriving during the marker slot itself is kept for the next marker.
  always_comb begin
    err_req_d = iErrInj | (err_req_q & (state_q != S_MARK));
    marker    = err_req_q ? 20'h00000 : 20'hFFFFF;
  end
  always_ff @(posedge iSclk or negedge iRstN)
    if (!iRstN) err_req_q <= 1'b0;
    else        err_req_q <= err_req_d;
`else
  logic unused_err_inj;
  assign unused_err_inj = iErrInj;
  assign marker = 20'hFFFFF;
`endif
  always_comb begin
    push    = iValid & oReady;
    pop     = (state_q == S_PAY) && (level_q != '0);
    last    = slot_q == SW'(FRAME_LEN - 1);
    state_d = state_q == S_OFF  ? (iEn ? S_MARK : S_OFF) :
              state_q == S_MARK ? S_PAY :
              state_q == S_PAY  ? (last ? (iEn ? S_MARK : S_OFF) : S_PAY) : S_OFF;
    slot_d  = state_q == S_MARK ? SW'(1) :
              (state_q == S_PAY && !last) ? slot_q + SW'(1) : '0;
    // Non-marker words keep bit 18 clear so payload can never alias the marker.
    link_d  = state_q == S_MARK ? marker :
              pop ? {2'b10, mem_q[rptr_q]} : 20'h00000;
    fcnt_d  = fcnt_q + 16'(state_q == S_MARK);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
  end
  always_ff @(posedge iSclk or negedge iRstN)
    if (!iRstN) begin
      state_q <= S_OFF;
      slot_q  <= '0;
      link_q  <= 20'h00000;
      fcnt_q  <= '0;
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      link_q  <= link_d;
      fcnt_q  <= fcnt_d;
      level_q <= level_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  always_ff @(posedge iSclk)
    if (push) mem_q[wptr_q] <= iData;
  assign oReady    = level_q != (AW+1)'(DEPTH);
  assign oD_Link   = link_q;
  assign oLevel    = level_q;
  assign oFrameCnt = fcnt_q;
endmodule

// File: tb/tb_link_tx_framer.sv
// tb_link_tx_framer: directed table plus hand sequences for framing, FIFO, enable drop, reset and error injection.
module tb_link_tx_framer;
  localparam int FL = 3900;
`ifdef LINK_TX_ERRINJ_EN
  localparam logic [19:0] ERR_MARK = 20'h00000;
`else
  localparam logic [19:0] ERR_MARK = 20'hFFFFF;
`endif
  logic        clk = 1'b0;
  logic        rst_n, en, val, err;
  logic [17:0] dat;
  logic        ready;
  logic [19:0] link;
  logic [4:0]  level;
  logic [15:0] fcnt;
  int          passed = 0, total = 0, n, s, bad;
  logic [19:0] expc [10];
  typedef struct {
    logic        en;
    logic        val;
    logic [17:0] d;
    logic [19:0] link;
    logic [4:0]  level;
    logic        ready;
    logic [15:0] fcnt;
  } vec_t;
  vec_t tbl [8];
  link_tx_framer #(.FRAME_LEN(FL), .DEPTH(16)) dut (
    .iSclk(clk), .iRstN(rst_n), .iEn(en), .iData(dat), .iValid(val), .oReady(ready),
    .iErrInj(err), .oD_Link(link), .oLevel(level), .oFrameCnt(fcnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask
  task automatic wm(input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (link == 20'hFFFFF) begin
        cnt = i;
        break;
      end
    end
  endtask
  initial begin
    tbl[0] = '{1'b0, 1'b1, 18'h3FFFF, 20'h00000, 5'd1, 1'b1, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 18'h00000, 20'h00000, 5'd2, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 18'h12345, 20'hFFFFF, 5'd3, 1'b1, 16'd1};
    tbl[3] = '{1'b1, 1'b0, 18'h00000, 20'hBFFFF, 5'd2, 1'b1, 16'd1};
    tbl[4] = '{1'b1, 1'b0, 18'h00000, 20'h80000, 5'd1, 1'b1, 16'd1};
    tbl[5] = '{1'b1, 1'b1, 18'h00001, 20'h92345, 5'd1, 1'b1, 16'd1};
    tbl[6] = '{1'b1, 1'b0, 18'h00000, 20'h80001, 5'd0, 1'b1, 16'd1};
    tbl[7] = '{1'b1, 1'b0, 18'h00000, 20'h00000, 5'd0, 1'b1, 16'd1};
    expc = '{20'h00000, 20'h80100, 20'h80101, 20'h80102, 20'hFFFFF,
             20'h80103, 20'h80104, 20'h80105, 20'h80106, 20'h80107};
    rst_n = 1'b0; en = 1'b0; val = 1'b0; err = 1'b0; dat = '0;
    tick(); tick();
    chk("rst_link", link, 20'h0);
    chk("rst_ready", ready, 1);
    chk("rst_level", level, 0);
    chk("rst_fcnt", fcnt, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      en = tbl[i].en; val = tbl[i].val; dat = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_link", i), link, tbl[i].link);
      chk($sformatf("tbl%0d_level", i), level, tbl[i].level);
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].ready);
      chk($sformatf("tbl%0d_fcnt", i), fcnt, tbl[i].fcnt);
    end
    wm(FL + 5, n);
    chk("gap1", n, FL - 5);
    chk("fcnt2", fcnt, 2);
    wm(FL + 5, n);
    chk("gap2", n, FL);
    chk("fcnt3", fcnt, 3);
    // Fill with framing off, then drain.
    en = 1'b0; val = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    val = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dat = 18'(i);
      tick();
      if (i == 14) chk("fill15_ready", ready, 1);
      if (i == 15) chk("fill16_ready", ready, 0);
      if (i == 15) chk("fill16_level", level, 16);
    end
    chk("full_level", level, 16);
    val = 1'b0; en = 1'b1;
    tick();
    chk("drain_pre", link, 20'h0);
    tick();
    chk("drain_mark", link, 20'hFFFFF);
    chk("drain_mark_level", level, 16);
    chk("drain_mark_ready", ready, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("drain%0d", i), link, 20'h80000 | 20'(i));
      if (i == 0) chk("drain_ready_back", ready, 1);
      if (i == 0) chk("drain_level15", level, 15);
    end
    tick();
    chk("drain_idle", link, 20'h0);
    chk("drain_empty", level, 0);
    // Stream across a frame boundary.
    s = 17;
    while (s < FL - 5) begin tick(); s++; end
    for (int k = 0; k < 10; k++) begin
      val = 1'b1; dat = 18'h100 + 18'(k);
      tick();
      chk($sformatf("bnd%0d", k), link, expc[k]);
    end
    val = 1'b0;
    chk("bnd_level", level, 2);
    tick(); chk("bnd_tail0", link, 20'h80108);
    tick(); chk("bnd_tail1", link, 20'h80109);
    tick(); chk("bnd_idle", link, 20'h0);
    s = 8;
    // Drop enable mid-frame; the frame still completes.
    while (s < 100) begin tick(); s++; end
    en = 1'b0;
    while (s < FL - 3) begin tick(); s++; end
    val = 1'b1; dat = 18'h155;
    tick(); chk("late_push_slot", link, 20'h0);
    val = 1'b0;
    tick(); chk("last_slot_data", link, 20'h80155);
    tick(); chk("off_word", link, 20'h0);
    chk("off_fcnt", fcnt, 2);
    val = 1'b1; dat = 18'h0AA;
    tick();
    val = 1'b0;
    bad = 0;
    repeat (2 * FL) begin
      tick();
      if (link != 20'h0) bad++;
    end
    chk("off_quiet", bad, 0);
    chk("off_level", level, 1);
    chk("off_fcnt2", fcnt, 2);
    // Restart, then asynchronous reset mid-frame.
    en = 1'b1;
    wm(4, n);
    chk("restart_lat", n, 2);
    tick(); chk("held_word", link, 20'h800AA);
    val = 1'b1; dat = 18'h1; tick();
    dat = 18'h2; tick();
    val = 1'b0;
    chk("pre_rst_link", link, 20'h80001);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_link", link, 20'h0);
    chk("arst_level", level, 0);
    chk("arst_ready", ready, 1);
    chk("arst_fcnt", fcnt, 0);
    tick();
    rst_n = 1'b1;
    wm(4, n);
    chk("post_rst_lat", n, 2);
    chk("post_rst_fcnt", fcnt, 1);
    s = 0;
    while (s < 50) begin tick(); s++; end
    err = 1'b1; tick(); s++;
    err = 1'b1; tick(); s++;
    err = 1'b0;
    while (s < FL - 1) begin tick(); s++; end
    tick();
    chk("err_mark", link, ERR_MARK);
    chk("err_fcnt", fcnt, 2);
    wm(FL + 5, n);
    chk("err_next_gap", n, FL);
    chk("err_next_fcnt", fcnt, 3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
